// File: rtl/or_and_tree_pkg.sv
// ---------------------------------------------------------------------------
// or_and_tree_pkg
// Shared types and elaboration-time helpers for the alternating AND/OR
// reduction tree.
//   op_t         gate type of one tree level (AND or OR)
//   op_at_depth  gate type for a depth counted from the root (root = 0)
//   log2_int     ceil(log2(v)) for elaboration-time sizing
//   is_pow2      true when v is a power of two and at least 2
// ---------------------------------------------------------------------------
package or_and_tree_pkg;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_OR  = 1'b1
  } op_t;

  function automatic op_t op_at_depth(input int d);
    return ((d % 2) == 0) ? OP_AND : OP_OR;
  endfunction

  function automatic int log2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/or_and_tree_if.sv
// ---------------------------------------------------------------------------
// or_and_tree_if
// Operand / result bundle of or_and_tree_unit.
//   valid_i  X/Y qualify this cycle
//   X, Y     N-bit operands
//   valid_o  Z holds a result for an accepted input
//   Z        single-bit reduction result
// master: the block feeding operands; slave: the reduction unit.
// ---------------------------------------------------------------------------
interface or_and_tree_if #(
  parameter int N = 8
);
  logic         valid_i;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         valid_o;
  logic         Z;

  modport master (
    output valid_i, X, Y,
    input  valid_o, Z
  );

  modport slave (
    input  valid_i, X, Y,
    output valid_o, Z
  );
endinterface

// File: rtl/or_and_tree_level.sv
// ---------------------------------------------------------------------------
// or_and_tree_level
// One level of the reduction tree: W bits -> W/2 bits, pairing adjacent
// inputs (2k, 2k+1) -> k with a single gate type OP.
// Ports:
//   clk, rst_n  clock / async active-low reset (used only when PIPE=1)
//   valid_in    qualifies d
//   d           W input nodes
//   valid_out   qualifies q
//   q           W/2 output nodes
// PIPE=1 registers q and valid_out; q only updates for a valid input so the
// last result holds. PIPE=0 is a pure combinational pass.
// ---------------------------------------------------------------------------
module or_and_tree_level
  import or_and_tree_pkg::*;
#(
  parameter int  W    = 2,
  parameter op_t OP   = OP_AND,
  parameter bit  PIPE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_in,
  input  logic [W-1:0]   d,
  output logic           valid_out,
  output logic [W/2-1:0] q
);

  logic [W/2-1:0] red;

  always_comb begin
    red = '0;
    for (int k = 0; k < W/2; k++) begin
      red[k] = (OP == OP_AND) ? (d[2*k] & d[2*k+1]) : (d[2*k] | d[2*k+1]);
    end
  end

  if (PIPE) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_out <= 1'b0;
        q         <= '0;
      end else begin
        valid_out <= valid_in;
        if (valid_in) q <= red;
      end
    end
  end else begin : g_comb
    assign valid_out = valid_in;
    assign q         = red;
    // clk/rst_n have no load in the combinational variant
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
  end

endmodule

// File: rtl/or_and_tree_unit.sv
// ---------------------------------------------------------------------------
// or_and_tree_unit
// Alternating AND/OR reduction of X & Y with a registered, valid-qualified
// single-bit result. Leaves a[i] = X[i] & Y[i] reduce through log2(N) levels;
// depth d from the root (root = 0) uses AND for even d, OR for odd d.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    or_and_tree_if.slave (valid_i, X, Y in; valid_o, Z out)
// Build option:
//   OR_AND_TREE_PIPE_EN  register after the leaf stage and every level;
//                        latency log2(N)+1. Undefined: latency 1.
// ---------------------------------------------------------------------------
module or_and_tree_unit
  import or_and_tree_pkg::*;
#(
  parameter int N = 8
) (
  input logic           clk,
  input logic           rst_n,
  or_and_tree_if.slave  bus
);

  localparam int L = log2_int(N);

  if (!is_pow2(N)) begin : g_bad_n
    $error("or_and_tree_unit: N=%0d must be a power of two >= 2", N);
  end

  // All tree nodes packed leaves-first: level s (width N>>s) starts at
  // bit 2N - 2*(N>>s), so the root lands on bit 2N-2.
  logic [2*N-2:0] node;
  logic [L:0]     vld;
  logic [N-1:0]   leaf;
  logic           leaf_v;

`ifdef OR_AND_TREE_PIPE_EN
  localparam bit PIPE_EN = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leaf_v <= 1'b0;
      leaf   <= '0;
    end else begin
      leaf_v <= bus.valid_i;
      if (bus.valid_i) leaf <= bus.X & bus.Y;
    end
  end
`else
  localparam bit PIPE_EN = 1'b0;

  assign leaf_v = bus.valid_i;
  assign leaf   = bus.X & bus.Y;
`endif

  assign node[N-1:0] = leaf;
  assign vld[0]      = leaf_v;

  // Levels are indexed from the leaves; the root level is always registered
  // so that it doubles as the output register in the combinational build.
  for (genvar li = 0; li < L; li++) begin : g_lvl
    localparam int W       = N >> li;
    localparam int OFF_IN  = 2*N - 2*W;
    localparam int OFF_OUT = 2*N - W;
    localparam bit PIPE    = PIPE_EN || (li == L - 1);

    or_and_tree_level #(
      .W    (W),
      .OP   (op_at_depth(L - 1 - li)),
      .PIPE (PIPE)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (vld[li]),
      .d         (node[OFF_IN +: W]),
      .valid_out (vld[li+1]),
      .q         (node[OFF_OUT +: W/2])
    );
  end

  assign bus.valid_o = vld[L];
  assign bus.Z       = node[2*N-2];

endmodule

// File: tb/tb_or_and_tree_unit.sv
module tb_or_and_tree_unit;

`ifdef OR_AND_TREE_PIPE_EN
  localparam int LAT8 = 4;
  localparam int LAT4 = 3;
  localparam int LAT2 = 2;
`else
  localparam int LAT8 = 1;
  localparam int LAT4 = 1;
  localparam int LAT2 = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  or_and_tree_if #(.N(8)) bus8 ();
  or_and_tree_if #(.N(4)) bus4 ();
  or_and_tree_if #(.N(2)) bus2 ();

  or_and_tree_unit #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  or_and_tree_unit #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  or_and_tree_unit #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  // staged stimulus for the next step
  logic       d8_v, d4_v, d2_v;
  logic [7:0] d8_x, d8_y;
  logic [3:0] d4_x, d4_y;
  logic [1:0] d2_x, d2_y;

  // model: pending results per DUT and current expected outputs
  bit q8_v[$], q8_r[$], q4_v[$], q4_r[$], q2_v[$], q2_r[$];
  bit e8_v, e8_z, e4_v, e4_z, e2_v, e2_z;

  // Closed-form reference functions, written straight from the gate rules.
  function automatic bit ref8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] a;
    a = x & y;
    return ((a[0] & a[1]) | (a[2] & a[3])) & ((a[4] & a[5]) | (a[6] & a[7]));
  endfunction

  function automatic bit ref4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] a;
    a = x & y;
    return (a[0] | a[1]) & (a[2] | a[3]);
  endfunction

  function automatic bit ref2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] a;
    a = x & y;
    return a[0] & a[1];
  endfunction

  task automatic model_reset();
    q8_v.delete(); q8_r.delete(); q4_v.delete(); q4_r.delete(); q2_v.delete(); q2_r.delete();
    for (int i = 0; i < LAT8 - 1; i++) begin q8_v.push_back(1'b0); q8_r.push_back(1'b0); end
    for (int i = 0; i < LAT4 - 1; i++) begin q4_v.push_back(1'b0); q4_r.push_back(1'b0); end
    for (int i = 0; i < LAT2 - 1; i++) begin q2_v.push_back(1'b0); q2_r.push_back(1'b0); end
    e8_v = 0; e8_z = 0; e4_v = 0; e4_z = 0; e2_v = 0; e2_z = 0;
  endtask

  task automatic idle_all();
    d8_v = 0; d8_x = 8'($urandom); d8_y = 8'($urandom);
    d4_v = 0; d4_x = 4'($urandom); d4_y = 4'($urandom);
    d2_v = 0; d2_x = 2'($urandom); d2_y = 2'($urandom);
  endtask

  // Apply staged inputs at negedge, advance one clock, update expectations.
  task automatic step();
    bit r;
    @(negedge clk);
    bus8.valid_i = d8_v; bus8.X = d8_x; bus8.Y = d8_y;
    bus4.valid_i = d4_v; bus4.X = d4_x; bus4.Y = d4_y;
    bus2.valid_i = d2_v; bus2.X = d2_x; bus2.Y = d2_y;
    q8_v.push_back(d8_v); q8_r.push_back(ref8(d8_x, d8_y));
    q4_v.push_back(d4_v); q4_r.push_back(ref4(d4_x, d4_y));
    q2_v.push_back(d2_v); q2_r.push_back(ref2(d2_x, d2_y));
    @(posedge clk);
    #1;
    e8_v = q8_v.pop_front(); r = q8_r.pop_front(); if (e8_v) e8_z = r;
    e4_v = q4_v.pop_front(); r = q4_r.pop_front(); if (e4_v) e4_z = r;
    e2_v = q2_v.pop_front(); r = q2_r.pop_front(); if (e2_v) e2_z = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.valid_i = 0; bus8.X = '1; bus8.Y = '1;
    bus4.valid_i = 0; bus4.X = '1; bus4.Y = '1;
    bus2.valid_i = 0; bus2.X = '1; bus2.Y = '1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 6;
    if (bus8.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid8: got %b expected 0", bus8.valid_o); end
    if (bus8.Z       !== 1'b0) begin n_fail++; $display("FAIL reset_z8: got %b expected 0", bus8.Z); end
    if (bus4.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b expected 0", bus4.valid_o); end
    if (bus4.Z       !== 1'b0) begin n_fail++; $display("FAIL reset_z4: got %b expected 0", bus4.Z); end
    if (bus2.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b expected 0", bus2.valid_o); end
    if (bus2.Z       !== 1'b0) begin n_fail++; $display("FAIL reset_z2: got %b expected 0", bus2.Z); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_all_ones();
    int lat;
    idle_all();
    d8_v = 1; d8_x = 8'hFF; d8_y = 8'hFF;
    step();
    lat = 1;
    idle_all();
    while (bus8.valid_o !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    n_checks += 2;
    if (lat != LAT8) begin n_fail++; $display("FAIL all_ones_latency: got %0d expected %0d", lat, LAT8); end
    if (bus8.Z !== 1'b1) begin n_fail++; $display("FAIL all_ones_z: got %b expected 1", bus8.Z); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[8] = '{8'hFF, 8'hAA, 8'h55, 8'hF0, 8'h01, 8'h80, 8'h00, 8'hFF};
    logic [7:0] ys[8] = '{8'hFF, 8'hAA, 8'h55, 8'hF0, 8'h01, 8'h80, 8'hFF, 8'h00};
    bit want[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit got[$];
    for (int i = 0; i < 8 + LAT8; i++) begin
      idle_all();
      if (i < 8) begin d8_v = 1; d8_x = xs[i]; d8_y = ys[i]; end
      step();
      if (bus8.valid_o === 1'b1) got.push_back(bus8.Z);
      n_checks += 2;
      if (bus8.valid_o !== e8_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, bus8.valid_o, e8_v); end
      if (bus8.Z !== e8_z) begin n_fail++; $display("FAIL b2b_z[%0d]: got %b expected %b", i, bus8.Z, e8_z); end
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d results expected 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got[i] !== want[i]) begin n_fail++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, got[i], want[i]); end
      end
    end
  endtask

  task automatic test_small_widths();
    logic [3:0] v4[3] = '{4'hF, 4'h5, 4'h3};
    bit w4[3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] v2[2] = '{2'b11, 2'b01};
    bit w2[2] = '{1'b1, 1'b0};
    bit g4[$];
    bit g2[$];
    for (int i = 0; i < 3 + LAT4; i++) begin
      idle_all();
      if (i < 3) begin d4_v = 1; d4_x = v4[i]; d4_y = v4[i]; end
      if (i < 2) begin d2_v = 1; d2_x = v2[i]; d2_y = v2[i]; end
      step();
      if (bus4.valid_o === 1'b1) g4.push_back(bus4.Z);
      if (bus2.valid_o === 1'b1) g2.push_back(bus2.Z);
      n_checks += 2;
      if (bus4.valid_o !== e4_v || bus4.Z !== e4_z) begin
        n_fail++; $display("FAIL n4_step[%0d]: got v=%b z=%b expected v=%b z=%b", i, bus4.valid_o, bus4.Z, e4_v, e4_z);
      end
      if (bus2.valid_o !== e2_v || bus2.Z !== e2_z) begin
        n_fail++; $display("FAIL n2_step[%0d]: got v=%b z=%b expected v=%b z=%b", i, bus2.valid_o, bus2.Z, e2_v, e2_z);
      end
    end
    n_checks += 2;
    if (g4.size() != 3) begin n_fail++; $display("FAIL n4_count: got %0d expected 3", g4.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (g4[i] !== w4[i]) begin n_fail++; $display("FAIL n4_directed[%0d]: got %b expected %b", i, g4[i], w4[i]); end
    end
    if (g2.size() != 2) begin n_fail++; $display("FAIL n2_count: got %0d expected 2", g2.size()); end
    else for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (g2[i] !== w2[i]) begin n_fail++; $display("FAIL n2_directed[%0d]: got %b expected %b", i, g2[i], w2[i]); end
    end
  endtask

  task automatic test_hold();
    idle_all();
    d8_v = 1; d8_x = 8'hFF; d8_y = 8'hFF;
    step();
    for (int i = 0; i < LAT8 + 4; i++) begin
      idle_all();
      step();
    end
    n_checks += 2;
    if (bus8.valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_valid: got %b expected 0", bus8.valid_o); end
    if (bus8.Z !== 1'b1) begin n_fail++; $display("FAIL hold_z: got %b expected 1", bus8.Z); end
  endtask

  task automatic test_exhaustive_n4();
    int first = -1;
    int k = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        idle_all();
        d4_v = 1; d4_x = 4'(x); d4_y = 4'(y);
        step();
        k++;
        if (first < 0 && bus4.valid_o === 1'b1) first = k;
        n_checks++;
        if (bus4.valid_o !== e4_v || bus4.Z !== e4_z) begin
          n_fail++; $display("FAIL exh4 x=%h y=%h: got v=%b z=%b expected v=%b z=%b", x, y, bus4.valid_o, bus4.Z, e4_v, e4_z);
        end
      end
    end
    for (int i = 0; i < LAT4; i++) begin
      idle_all();
      step();
      n_checks++;
      if (bus4.valid_o !== e4_v || bus4.Z !== e4_z) begin
        n_fail++; $display("FAIL exh4_flush[%0d]: got v=%b z=%b expected v=%b z=%b", i, bus4.valid_o, bus4.Z, e4_v, e4_z);
      end
    end
    n_checks++;
    if (first != LAT4) begin n_fail++; $display("FAIL exh4_latency: got %0d expected %0d", first, LAT4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300 + LAT8; i++) begin
      idle_all();
      if (i < 300) begin
        d8_v = ($urandom_range(9, 0) < 7);
        d8_x = 8'($urandom | $urandom);
        d8_y = 8'($urandom | $urandom);
        d2_v = ($urandom_range(1, 0) == 1);
      end
      step();
      n_checks += 2;
      if (bus8.valid_o !== e8_v || bus8.Z !== e8_z) begin
        n_fail++; $display("FAIL rand8[%0d]: got v=%b z=%b expected v=%b z=%b", i, bus8.valid_o, bus8.Z, e8_v, e8_z);
      end
      if (bus2.valid_o !== e2_v || bus2.Z !== e2_z) begin
        n_fail++; $display("FAIL rand2[%0d]: got v=%b z=%b expected v=%b z=%b", i, bus2.valid_o, bus2.Z, e2_v, e2_z);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < LAT8 + 1; i++) begin
      idle_all();
      d8_v = 1; d8_x = 8'hFF; d8_y = 8'hFF;
      d4_v = 1; d4_x = 4'hF;  d4_y = 4'hF;
      step();
    end
    n_checks++;
    if (bus8.valid_o !== 1'b1 || bus8.Z !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset8: got v=%b z=%b expected v=1 z=1", bus8.valid_o, bus8.Z);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (bus8.valid_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid8: got %b expected 0", bus8.valid_o); end
    if (bus8.Z !== 1'b0) begin n_fail++; $display("FAIL async_reset_z8: got %b expected 0", bus8.Z); end
    if (bus4.valid_o !== 1'b0 || bus4.Z !== 1'b0) begin
      n_fail++; $display("FAIL async_reset4: got v=%b z=%b expected v=0 z=0", bus4.valid_o, bus4.Z);
    end
    @(negedge clk);
    bus8.valid_i = 0; bus4.valid_i = 0; bus2.valid_i = 0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < LAT8 + 2; i++) begin
      idle_all();
      step();
      n_checks++;
      if (bus8.valid_o !== 1'b0 || bus4.valid_o !== 1'b0 || bus8.Z !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_stale[%0d]: got v8=%b v4=%b z8=%b expected 0 0 0", i, bus8.valid_o, bus4.valid_o, bus8.Z);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_small_widths();
    test_hold();
    test_exhaustive_n4();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
